// File: rtl/bus_cycle_sequencer.sv
// bus_cycle_sequencer: runs one 8088 bus cycle at a time against the AXI4-Lite
// master port, the internal ROM/RAM, or the LED register, and holds cpu_ready low
// until the access completes.
// Optional feature: define BUS_TIMEOUT_EN to add an AXI response watchdog
// (TIMEOUT_CYCLES) and a DRAIN state that retires the stuck transfer.
module bus_cycle_sequencer #(
  parameter logic [7:0] UNKNOWN_RDATA = 8'hFF
`ifdef BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  addr_type,
  input  logic [31:0] a32,
  input  logic        is_read,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        int_rom_en,
  output logic        int_ram_en,
  output logic        int_we,
  input  logic [7:0]  int_rdata,
  output logic [7:0]  led
);

  // Request-type encodings shared with the address converter (addr_map.svh).
  localparam logic [2:0] ADDR_TYPE_NOT_OP       = 3'd0;
  localparam logic [2:0] ADDR_TYPE_AXI          = 3'd1;
  localparam logic [2:0] ADDR_TYPE_INTERNAL_ROM = 3'd2;
  localparam logic [2:0] ADDR_TYPE_INTERNAL_RAM = 3'd3;
  localparam logic [2:0] ADDR_TYPE_INTERNAL_LED = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AXI_REQ  = 3'd1,
    AXI_RESP = 3'd2,
    INT_WAIT = 3'd3,
    DONE     = 3'd4
`ifdef BUS_TIMEOUT_EN
    , DRAIN  = 3'd5
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        awvalid_q, awvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        int_rom_en_q, int_rom_en_d;
  logic        int_ram_en_q, int_ram_en_d;
  logic        int_we_q, int_we_d;
  logic [7:0]  led_q, led_d;
  logic [1:0]  lane_q, lane_d;   // byte lane of the latched address
  logic        rd_q, rd_d;       // latched is_read
`ifdef BUS_TIMEOUT_EN
  logic [31:0] timeout_cnt_q, timeout_cnt_d;
`endif

  // Next-state, handshake and output computation for the sequencer FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path through the case
    // statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    cpu_rdata_d  = cpu_rdata_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    araddr_d     = araddr_q;
    led_d        = led_q;
    lane_d       = lane_q;
    rd_d         = rd_q;
    int_rom_en_d = 1'b0;
    int_ram_en_d = 1'b0;
    int_we_d     = 1'b0;

    // AXI handshakes progress the same way in every state; when nothing is
    // outstanding these are no-ops. Each valid drops on its own ready, the
    // response ready rises once the address (and data) phase is complete.
    arvalid_d = arvalid_q & ~m_axi_arready;
    awvalid_d = awvalid_q & ~m_axi_awready;
    wvalid_d  = wvalid_q  & ~m_axi_wready;
    rready_d  = rready_q;
    bready_d  = bready_q;
    if (arvalid_q && m_axi_arready) rready_d = 1'b1;
    if ((awvalid_q || wvalid_q) && !awvalid_d && !wvalid_d) bready_d = 1'b1;
    if (rready_q && m_axi_rvalid) rready_d = 1'b0;
    if (bready_q && m_axi_bvalid) bready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (addr_type != ADDR_TYPE_NOT_OP) begin
          lane_d = a32[1:0];
          rd_d   = is_read;
          case (addr_type)
            ADDR_TYPE_AXI: begin
              state_d = AXI_REQ;
              if (is_read) begin
                araddr_d  = a32;
                arvalid_d = 1'b1;
              end else begin
                awaddr_d  = a32;
                wdata_d   = {4{cpu_wdata}};
                wstrb_d   = 4'b0001 << a32[1:0];
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
              end
            end
            ADDR_TYPE_INTERNAL_ROM: begin
              int_rom_en_d = 1'b1;
              state_d      = INT_WAIT;
            end
            ADDR_TYPE_INTERNAL_RAM: begin
              int_ram_en_d = 1'b1;
              int_we_d     = ~is_read;
              state_d      = INT_WAIT;
            end
            ADDR_TYPE_INTERNAL_LED: begin
              led_d   = cpu_wdata;
              state_d = DONE;
            end
            default: begin  // unknown and unassigned encodings
              cpu_rdata_d = UNKNOWN_RDATA;
              state_d     = DONE;
            end
          endcase
        end
      end
      AXI_REQ: begin
        if (!arvalid_d && !awvalid_d && !wvalid_d) state_d = AXI_RESP;
      end
      AXI_RESP: begin
        if (rready_q && m_axi_rvalid) begin
          cpu_rdata_d = m_axi_rdata[{lane_q, 3'b000} +: 8];
          state_d     = DONE;
        end else if (bready_q && m_axi_bvalid) begin
          state_d = DONE;
        end
      end
      INT_WAIT: begin
        if (rd_q) cpu_rdata_d = int_rdata;
        state_d = DONE;
      end
      DONE: begin
        // Only a return to NOT_OP ends the cycle; a held request never retriggers.
        if (addr_type == ADDR_TYPE_NOT_OP) state_d = IDLE;
      end
`ifdef BUS_TIMEOUT_EN
      DRAIN: begin
        // Leave once the stuck transfer has retired and the CPU has ended its
        // cycle (now, or earlier while the drain was still pending).
        if (!arvalid_d && !rready_d && !awvalid_d && !wvalid_d && !bready_d &&
            (addr_type == ADDR_TYPE_NOT_OP || !cpu_ready_q))
          state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef BUS_TIMEOUT_EN
    // Watchdog counts every cycle spent waiting on the AXI slave.
    timeout_cnt_d = 32'd0;
    if (state_q == AXI_REQ || state_q == AXI_RESP) begin
      timeout_cnt_d = timeout_cnt_q + 32'd1;
      if ((state_d == AXI_REQ || state_d == AXI_RESP) &&
          timeout_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
        cpu_rdata_d = UNKNOWN_RDATA;
        state_d     = DRAIN;
      end
    end
`endif

    // READY is high in DONE; in DRAIN it is high until the CPU ends the cycle.
    cpu_ready_d = (state_d == DONE);
`ifdef BUS_TIMEOUT_EN
    if (state_d == DRAIN)
      cpu_ready_d = (state_q != DRAIN) ||
                    (cpu_ready_q && addr_type != ADDR_TYPE_NOT_OP);
`endif
  end

  // State and registered-output flops with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cpu_rdata_q   <= 8'h00;
      cpu_ready_q   <= 1'b0;
      awaddr_q      <= 32'h0;
      awvalid_q     <= 1'b0;
      wdata_q       <= 32'h0;
      wstrb_q       <= 4'h0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      araddr_q      <= 32'h0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      int_rom_en_q  <= 1'b0;
      int_ram_en_q  <= 1'b0;
      int_we_q      <= 1'b0;
      led_q         <= 8'h00;
      lane_q        <= 2'b00;
      rd_q          <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      timeout_cnt_q <= 32'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values that
      // existed before this edge, independent of statement order.
      state_q       <= state_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_ready_q   <= cpu_ready_d;
      awaddr_q      <= awaddr_d;
      awvalid_q     <= awvalid_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      int_rom_en_q  <= int_rom_en_d;
      int_ram_en_q  <= int_ram_en_d;
      int_we_q      <= int_we_d;
      led_q         <= led_d;
      lane_q        <= lane_d;
      rd_q          <= rd_d;
`ifdef BUS_TIMEOUT_EN
      timeout_cnt_q <= timeout_cnt_d;
`endif
    end
  end

  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_ready     = cpu_ready_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign int_rom_en    = int_rom_en_q;
  assign int_ram_en    = int_ram_en_q;
  assign int_we        = int_we_q;
  assign led           = led_q;

endmodule
